// File: rtl/avalon_onchip_ram_pipelined_pkg.sv
// Shared types and constants for the pipelined Avalon-MM on-chip RAM.
// Response codes, controller states and pipeline limits.
package avalon_ram_pkg;

   localparam logic [1:0] RESP_OKAY       = 2'b00;
   localparam logic [1:0] RESP_SLAVEERROR = 2'b10;

   localparam int MAX_READ_LATENCY = 2;

   typedef enum logic {
      CLEAR,
      READY
   } state_e;

endpackage

// File: rtl/avalon_onchip_ram_pipelined_if.sv
// Avalon-MM slave bus bundle for the on-chip RAM.
// Master drives requests, slave returns data and status.
interface avalon_onchip_ram_pipelined_if #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 16
);

   logic [ADDR_WIDTH-1:0]   address;
   logic [DATA_WIDTH/8-1:0] byteenable;
   logic                    chipselect;
   logic                    read;
   logic                    write;
   logic [DATA_WIDTH-1:0]   writedata;
   logic [DATA_WIDTH-1:0]   readdata;
   logic                    readdatavalid;
   logic                    waitrequest;
   logic [1:0]              response;

   modport master (
      output address, byteenable, chipselect,
      output read, write, writedata,
      input  readdata, readdatavalid,
      input  waitrequest, response
   );

   modport slave (
      input  address, byteenable, chipselect,
      input  read, write, writedata,
      output readdata, readdatavalid,
      output waitrequest, response
   );

endinterface

// File: rtl/avalon_onchip_ram_pipelined_ram_sp_be.sv
// Inferred single-port RAM with byte-lane writes.
// Read data is registered; ce freezes both ports.
module ram_sp_be #(
   parameter int DATA_WIDTH = 32,
   parameter int DEPTH      = 40000,
   parameter int ADDR_WIDTH = 16
) (
   input  logic                    clk,
   input  logic                    ce,
   input  logic                    we,
   input  logic [DATA_WIDTH/8-1:0] be,
   input  logic [ADDR_WIDTH-1:0]   addr,
   input  logic [DATA_WIDTH-1:0]   wdata,
   output logic [DATA_WIDTH-1:0]   rdata
);

   localparam int BE_W = DATA_WIDTH / 8;

   logic [DATA_WIDTH-1:0] mem [DEPTH];

   // Lane-masked write and read-first registered read
   always_ff @(posedge clk) begin
      if (ce) begin
         if (we) begin
            for (int i = 0; i < BE_W; i++) begin
               if (be[i]) begin
                  mem[addr][8*i +: 8] <= wdata[8*i +: 8];
               end
            end
         end
         rdata <= mem[addr];
      end
   end

endmodule

// File: rtl/avalon_onchip_ram_pipelined.sv
// Avalon-MM on-chip RAM with pipelined reads and zero-fill.
// Out-of-range accesses return SLAVEERROR and never touch memory.
module avalon_onchip_ram_pipelined
   import avalon_ram_pkg::*;
#(
   parameter int DATA_WIDTH     = 32,
   parameter int DEPTH          = 40000,
   parameter int ADDR_WIDTH     = 16,
   parameter int READ_LATENCY   = 1,
   parameter int CLEAR_ON_RESET = 1
) (
   input  logic clk,
   input  logic reset_n,
   input  logic clken,
   input  logic reset_req,
   output logic init_done,
   avalon_onchip_ram_pipelined_if.slave s
);

   localparam int BE_W   = DATA_WIDTH / 8;
   localparam int RAM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [31:0] DEPTH_U = DEPTH;
   localparam logic [RAM_AW-1:0] LAST = RAM_AW'(DEPTH - 1);

   state_e state;
   state_e state_nxt;

   logic [RAM_AW-1:0]     clr_cnt;
   logic                  en;
   logic                  clearing;
   logic                  last_clr;
   logic                  in_range;
   logic                  accept;
   logic                  wr_acc;
   logic                  rd_acc;
   logic                  ram_we;
   logic [BE_W-1:0]       ram_be;
   logic [RAM_AW-1:0]     ram_addr;
   logic [DATA_WIDTH-1:0] ram_wdata;
   logic [DATA_WIDTH-1:0] ram_q;
   logic                  v1;
   logic                  e1;
   logic [DATA_WIDTH-1:0] d1;
   logic [1:0]            r1;

   assign en       = clken & ~reset_req;
   assign last_clr = (clr_cnt == LAST);
   assign in_range = 32'(s.address) < DEPTH_U;

   assign s.waitrequest = (state != READY) | ~en;

   assign accept = s.chipselect & (s.read | s.write) & ~s.waitrequest;
   assign wr_acc = accept & s.write;
   assign rd_acc = accept & s.read & ~s.write;

   // Controller state register
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= CLEAR;
      end else if (en) begin
         state <= state_nxt;
      end
   end

   // Leave CLEAR after the last word is zeroed
   always_comb begin
      state_nxt = state;
      unique case (state)
         CLEAR: begin
            if (CLEAR_ON_RESET == 0 || last_clr) begin
               state_nxt = READY;
            end
         end
         READY: state_nxt = READY;
      endcase
   end

   // State-derived outputs
   always_comb begin
      clearing  = 1'b0;
      init_done = 1'b0;
      unique case (state)
         CLEAR: clearing  = (CLEAR_ON_RESET != 0);
         READY: init_done = 1'b1;
      endcase
   end

   // Zero-fill address counter, restarts on every reset
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         clr_cnt <= '0;
      end else if (en && clearing && !last_clr) begin
         clr_cnt <= clr_cnt + RAM_AW'(1);
      end
   end

   // RAM port mux: fill sequence or bus access
   always_comb begin
      ram_we    = (en & clearing) | (wr_acc & in_range);
      ram_be    = s.byteenable;
      ram_wdata = s.writedata;
      ram_addr  = in_range ? s.address[RAM_AW-1:0] : '0;
      if (clearing) begin
         ram_be    = '1;
         ram_wdata = '0;
         ram_addr  = clr_cnt;
      end
   end

   ram_sp_be #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (DEPTH),
      .ADDR_WIDTH (RAM_AW)
   ) u_ram (
      .clk   (clk),
      .ce    (en),
      .we    (ram_we),
      .be    (ram_be),
      .addr  (ram_addr),
      .wdata (ram_wdata),
      .rdata (ram_q)
   );

   // First read stage tracks the RAM output register
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         v1 <= 1'b0;
         e1 <= 1'b0;
      end else if (en) begin
         v1 <= rd_acc;
         e1 <= rd_acc & ~in_range;
      end
   end

   assign d1 = (v1 & ~e1) ? ram_q : '0;
   assign r1 = e1 ? RESP_SLAVEERROR : RESP_OKAY;

   if (READ_LATENCY == MAX_READ_LATENCY) begin : g_out_reg
      logic                  v2;
      logic [DATA_WIDTH-1:0] d2;
      logic [1:0]            r2;

      // Extra output register stage
      always_ff @(posedge clk or negedge reset_n) begin
         if (!reset_n) begin
            v2 <= 1'b0;
            d2 <= '0;
            r2 <= RESP_OKAY;
         end else if (en) begin
            v2 <= v1;
            d2 <= d1;
            r2 <= r1;
         end
      end

      assign s.readdatavalid = v2 & en;
      assign s.readdata      = d2;
      assign s.response      = r2;
   end else begin : g_no_reg
      assign s.readdatavalid = v1 & en;
      assign s.readdata      = d1;
      assign s.response      = r1;
   end

endmodule

// File: tb/tb_avalon_onchip_ram_pipelined.sv
// Bench for the pipelined on-chip RAM, latency 1 and 2 side by side.
// Fixed vectors, corner sequences and random traffic against a model.
module tb_avalon_onchip_ram_pipelined;

   localparam int DEPTH = 16;

   logic clk;
   logic reset_n;
   logic clken;
   logic reset_req;
   logic done1;
   logic done2;

   avalon_onchip_ram_pipelined_if #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) bus1 ();
   avalon_onchip_ram_pipelined_if #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) bus2 ();

   assign bus2.address    = bus1.address;
   assign bus2.byteenable = bus1.byteenable;
   assign bus2.chipselect = bus1.chipselect;
   assign bus2.read       = bus1.read;
   assign bus2.write      = bus1.write;
   assign bus2.writedata  = bus1.writedata;

   avalon_onchip_ram_pipelined #(
      .DATA_WIDTH(32), .DEPTH(DEPTH), .ADDR_WIDTH(5),
      .READ_LATENCY(1), .CLEAR_ON_RESET(1)
   ) dut1 (
      .clk(clk), .reset_n(reset_n), .clken(clken),
      .reset_req(reset_req), .init_done(done1), .s(bus1)
   );

   avalon_onchip_ram_pipelined #(
      .DATA_WIDTH(32), .DEPTH(DEPTH), .ADDR_WIDTH(5),
      .READ_LATENCY(2), .CLEAR_ON_RESET(1)
   ) dut2 (
      .clk(clk), .reset_n(reset_n), .clken(clken),
      .reset_req(reset_req), .init_done(done2), .s(bus2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] d;
      logic [1:0]  r;
      int          due;
   } beat_t;

   typedef struct {
      bit          wr;
      int          addr;
      logic [3:0]  be;
      logic [31:0] wdata;
      logic [31:0] exp_d;
      logic [1:0]  exp_r;
   } vec_t;

   int n_chk;
   int n_fail;
   int cyc;
   int en_edges;
   int clr_cnt;
   bit ready;
   logic [31:0] mdl [DEPTH];
   beat_t q1[$];
   beat_t q2[$];
   int beat_val[$];
   int beat_cyc[$];
   logic s1_v, s1_w, s2_v;
   logic [31:0] s1_d, s2_d;
   logic [1:0] s1_r, s2_r;
   vec_t tbl[12];

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (cycle %0d)",
                  name, act, exp, cyc);
      end
   endtask

   task automatic drive(input bit cs, input bit rd, input bit wr,
                        input int a, input logic [3:0] be,
                        input logic [31:0] wd);
      bus1.chipselect = cs;
      bus1.read       = rd;
      bus1.write      = wr;
      bus1.address    = 5'(a);
      bus1.byteenable = be;
      bus1.writedata  = wd;
   endtask

   // one clock: check at negedge, advance the model at posedge
   task automatic step();
      logic en, exp_w, acc, ev;
      int a;
      beat_t b;
      @(negedge clk);
      cyc++;
      en    = clken && !reset_req;
      exp_w = !ready || !en;
      chk("waitrequest_l1", 32'(bus1.waitrequest), 32'(exp_w));
      chk("waitrequest_l2", 32'(bus2.waitrequest), 32'(exp_w));
      chk("init_done_l1", 32'(done1), 32'(ready));
      chk("init_done_l2", 32'(done2), 32'(ready));
      ev = en && q1.size() > 0 && q1[0].due == en_edges;
      chk("rdvalid_l1", 32'(bus1.readdatavalid), 32'(ev));
      if (ev) begin
         b = q1.pop_front();
         chk("rdata_l1", bus1.readdata, b.d);
         chk("resp_l1", 32'(bus1.response), 32'(b.r));
      end
      ev = en && q2.size() > 0 && q2[0].due == en_edges;
      chk("rdvalid_l2", 32'(bus2.readdatavalid), 32'(ev));
      if (ev) begin
         b = q2.pop_front();
         chk("rdata_l2", bus2.readdata, b.d);
         chk("resp_l2", 32'(bus2.response), 32'(b.r));
      end
      s1_v = bus1.readdatavalid;
      s1_w = bus1.waitrequest;
      s1_d = bus1.readdata;
      s1_r = bus1.response;
      s2_v = bus2.readdatavalid;
      s2_d = bus2.readdata;
      s2_r = bus2.response;
      if (bus1.readdatavalid) begin
         beat_val.push_back(int'(bus1.readdata));
         beat_cyc.push_back(cyc);
      end
      acc = !exp_w && bus1.chipselect && (bus1.read || bus1.write);
      a = int'(bus1.address);
      @(posedge clk);
      if (reset_n && en) begin
         en_edges++;
         if (!ready) begin
            clr_cnt++;
            if (clr_cnt == DEPTH) begin
               ready = 1'b1;
               foreach (mdl[i]) mdl[i] = '0;
            end
         end
         if (acc && bus1.write && a < DEPTH) begin
            for (int l = 0; l < 4; l++) begin
               if (bus1.byteenable[l]) begin
                  mdl[a][8*l +: 8] = bus1.writedata[8*l +: 8];
               end
            end
         end
         if (acc && bus1.read && !bus1.write) begin
            b.d   = (a < DEPTH) ? mdl[a] : 32'h0;
            b.r   = (a < DEPTH) ? 2'b00 : 2'b10;
            b.due = en_edges;
            q1.push_back(b);
            b.due = en_edges + 1;
            q2.push_back(b);
         end
      end
      #1;
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      #1;
      chk("rst_rdata_l1", bus1.readdata, 32'h0);
      chk("rst_rdata_l2", bus2.readdata, 32'h0);
      chk("rst_rdvalid_l1", 32'(bus1.readdatavalid), 32'h0);
      chk("rst_rdvalid_l2", 32'(bus2.readdatavalid), 32'h0);
      chk("rst_wait_l1", 32'(bus1.waitrequest), 32'h1);
      chk("rst_wait_l2", 32'(bus2.waitrequest), 32'h1);
      chk("rst_resp_l1", 32'(bus1.response), 32'h0);
      chk("rst_resp_l2", 32'(bus2.response), 32'h0);
      chk("rst_done_l1", 32'(done1), 32'h0);
      chk("rst_done_l2", 32'(done2), 32'h0);
      q1.delete();
      q2.delete();
      ready   = 1'b0;
      clr_cnt = 0;
      step();
      step();
      reset_n = 1'b1;
   endtask

   task automatic wait_init();
      int n;
      n = 0;
      for (int i = 0; i < 40; i++) begin
         step();
         if (!s1_w) break;
         n++;
      end
      chk("init_wait_cycles", 32'(n), 32'd16);
      chk("init_done_after", 32'(done1), 32'h1);
   endtask

   task automatic stall_test(input bit use_req);
      drive(1, 1, 0, 2, 4'hf, 32'h0);
      step();
      drive(0, 0, 0, 0, 4'h0, 32'h0);
      if (use_req) reset_req = 1'b1;
      else clken = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
         chk("stall_rdvalid", 32'(s1_v), 32'h0);
         chk("stall_wait", 32'(s1_w), 32'h1);
      end
      clken = 1'b1;
      reset_req = 1'b0;
      step();
      chk("stall_beat_valid", 32'(s1_v), 32'h1);
      chk("stall_beat_data", s1_d, 32'h2);
      step();
      chk("stall_beat_once", 32'(s1_v), 32'h0);
      step();
   endtask

   initial begin
      n_chk = 0;
      n_fail = 0;
      cyc = 0;
      en_edges = 0;
      clr_cnt = 0;
      ready = 1'b0;
      reset_n = 1'b0;
      clken = 1'b1;
      reset_req = 1'b0;
      drive(0, 0, 0, 0, 4'h0, 32'h0);

      tbl[0]  = '{1, 3,  4'hf, 32'hDEADBEEF, 32'h0, 2'b00};
      tbl[1]  = '{1, 3,  4'h5, 32'h11223344, 32'h0, 2'b00};
      tbl[2]  = '{0, 3,  4'h0, 32'h0, 32'hDE22BE44, 2'b00};
      tbl[3]  = '{0, 5,  4'hf, 32'h0, 32'h00000000, 2'b00};
      tbl[4]  = '{1, 16, 4'hf, 32'hFFFFFFFF, 32'h0, 2'b00};
      tbl[5]  = '{0, 16, 4'hf, 32'h0, 32'h00000000, 2'b10};
      tbl[6]  = '{0, 0,  4'hf, 32'h0, 32'h00000000, 2'b00};
      tbl[7]  = '{1, 7,  4'h0, 32'h12345678, 32'h0, 2'b00};
      tbl[8]  = '{0, 7,  4'h3, 32'h0, 32'h00000000, 2'b00};
      tbl[9]  = '{1, 9,  4'h3, 32'hAABBCCDD, 32'h0, 2'b00};
      tbl[10] = '{1, 9,  4'hc, 32'h11223344, 32'h0, 2'b00};
      tbl[11] = '{0, 9,  4'h0, 32'h0, 32'h1122CCDD, 2'b00};

      do_reset();
      wait_init();

      for (int i = 0; i < 12; i++) begin
         drive(1, !tbl[i].wr, tbl[i].wr, tbl[i].addr, tbl[i].be,
               tbl[i].wdata);
         step();
         drive(0, 0, 0, 0, 4'h0, 32'h0);
         if (!tbl[i].wr) begin
            step();
            chk($sformatf("vec%0d_valid_l1", i), 32'(s1_v), 32'h1);
            chk($sformatf("vec%0d_data_l1", i), s1_d, tbl[i].exp_d);
            chk($sformatf("vec%0d_resp_l1", i), 32'(s1_r),
                32'(tbl[i].exp_r));
            step();
            chk($sformatf("vec%0d_valid_l2", i), 32'(s2_v), 32'h1);
            chk($sformatf("vec%0d_data_l2", i), s2_d, tbl[i].exp_d);
            chk($sformatf("vec%0d_resp_l2", i), 32'(s2_r),
                32'(tbl[i].exp_r));
         end
      end

      for (int i = 0; i < 8; i++) begin
         drive(1, 0, 1, i, 4'hf, 32'(i));
         step();
      end
      beat_val.delete();
      beat_cyc.delete();
      for (int i = 0; i < 8; i++) begin
         drive(1, 1, 0, i, 4'hf, 32'h0);
         step();
      end
      drive(0, 0, 0, 0, 4'h0, 32'h0);
      for (int i = 0; i < 3; i++) step();
      chk("burst_beats", 32'(beat_val.size()), 32'd8);
      for (int i = 0; i < beat_val.size() && i < 8; i++) begin
         chk("burst_data", 32'(beat_val[i]), 32'(i));
         chk("burst_cycle", 32'(beat_cyc[i] - beat_cyc[0]), 32'(i));
      end

      stall_test(1'b0);
      stall_test(1'b1);

      do_reset();
      for (int i = 0; i < 7; i++) step();
      do_reset();
      wait_init();

      drive(1, 1, 0, 1, 4'hf, 32'h0);
      step();
      drive(0, 0, 0, 0, 4'h0, 32'h0);
      do_reset();
      wait_init();

      for (int i = 0; i < 400; i++) begin
         clken     = ($urandom % 8) != 0;
         reset_req = ($urandom % 16) == 0;
         drive(($urandom % 4) != 0, 1'($urandom), 1'($urandom),
               int'($urandom_range(0, 19)), 4'($urandom), $urandom);
         step();
      end
      clken = 1'b1;
      reset_req = 1'b0;
      drive(0, 0, 0, 0, 4'h0, 32'h0);
      for (int i = 0; i < 4; i++) step();
      chk("drain_l1", 32'(q1.size()), 32'h0);
      chk("drain_l2", 32'(q2.size()), 32'h0);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
